// File: rtl/sc_regpoint_matrix_if.sv
// -----------------------------------------------------------------------------
// sc_regpoint_matrix_if
// Groups the command inputs and the status outputs of sc_regpoint_matrix.
//   master : the upstream controller side. It drives the active-low commands,
//            the column shift and the row select, and it observes the status.
//   slave  : the matrix side (sc_regpoint_matrix).
// Signals:
//   SC_REGPOINT_MATRIX_clear_InLow          blank the frog (active low)
//   SC_REGPOINT_MATRIX_defaultscreen_InLow  place frog at start (active low)
//   SC_REGPOINT_MATRIX_load0_InLow          move up one row (active low)
//   SC_REGPOINT_MATRIX_load1_InLow          move down one row (active low)
//   SC_REGPOINT_MATRIX_shiftselection_InBus 01 = left, 10 = right, else hold
//   SC_REGPOINT_MATRIX_rowselect_InBus      row requested by the scanner
//   SC_REGPOINT_MATRIX_data_OutBus          registered pattern of that row
//   SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow  low when frog is in row 7
//   SC_REGPOINT_MATRIX_goal_OutHigh         one-cycle pulse on reaching row 0
//   SC_REGPOINT_MATRIX_movecount_OutBus     accepted moves, saturating
//   debugRow / debugCol / debugValid        live position state
// Commands are plain levels with no handshake. Each clock edge samples them,
// and a command held for N cycles applies N times.
// -----------------------------------------------------------------------------
interface sc_regpoint_matrix_if;
    logic       SC_REGPOINT_MATRIX_clear_InLow;
    logic       SC_REGPOINT_MATRIX_defaultscreen_InLow;
    logic       SC_REGPOINT_MATRIX_load0_InLow;
    logic       SC_REGPOINT_MATRIX_load1_InLow;
    logic [1:0] SC_REGPOINT_MATRIX_shiftselection_InBus;
    logic [2:0] SC_REGPOINT_MATRIX_rowselect_InBus;
    logic [7:0] SC_REGPOINT_MATRIX_data_OutBus;
    logic       SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow;
    logic       SC_REGPOINT_MATRIX_goal_OutHigh;
    logic [7:0] SC_REGPOINT_MATRIX_movecount_OutBus;
    logic [2:0] debugRow;
    logic [7:0] debugCol;
    logic       debugValid;

    modport master (
        output SC_REGPOINT_MATRIX_clear_InLow,
        output SC_REGPOINT_MATRIX_defaultscreen_InLow,
        output SC_REGPOINT_MATRIX_load0_InLow,
        output SC_REGPOINT_MATRIX_load1_InLow,
        output SC_REGPOINT_MATRIX_shiftselection_InBus,
        output SC_REGPOINT_MATRIX_rowselect_InBus,
        input  SC_REGPOINT_MATRIX_data_OutBus,
        input  SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow,
        input  SC_REGPOINT_MATRIX_goal_OutHigh,
        input  SC_REGPOINT_MATRIX_movecount_OutBus,
        input  debugRow,
        input  debugCol,
        input  debugValid
    );

    modport slave (
        input  SC_REGPOINT_MATRIX_clear_InLow,
        input  SC_REGPOINT_MATRIX_defaultscreen_InLow,
        input  SC_REGPOINT_MATRIX_load0_InLow,
        input  SC_REGPOINT_MATRIX_load1_InLow,
        input  SC_REGPOINT_MATRIX_shiftselection_InBus,
        input  SC_REGPOINT_MATRIX_rowselect_InBus,
        output SC_REGPOINT_MATRIX_data_OutBus,
        output SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow,
        output SC_REGPOINT_MATRIX_goal_OutHigh,
        output SC_REGPOINT_MATRIX_movecount_OutBus,
        output debugRow,
        output debugCol,
        output debugValid
    );
endinterface

// File: rtl/sc_regpoint_matrix.sv
// -----------------------------------------------------------------------------
// sc_regpoint_matrix
// Tracks the single frog point on an 8x8 LED matrix and serves one row at a
// time to the display scanner.
// Ports:
//   SC_REGPOINT_MATRIX_CLOCK_50     system clock; state changes on its rising edge
//   SC_REGPOINT_MATRIX_RESET_InHigh synchronous, active-high reset
//   matrixBus (slave)               commands in, row data and status out
// State: row (0 = top, 7 = bottom), col (one-hot, bit 7 = leftmost), valid.
// Command priority: clear > defaultscreen > load0 > load1 > shift.
// Only the highest-priority active command is considered. If that command
// cannot move the frog (edge of the matrix, or frog invalid), the cycle
// does nothing, and a lower-priority command is not tried instead.
// -----------------------------------------------------------------------------
module sc_regpoint_matrix (
    input  logic                 SC_REGPOINT_MATRIX_CLOCK_50,
    input  logic                 SC_REGPOINT_MATRIX_RESET_InHigh,
    sc_regpoint_matrix_if.slave  matrixBus
);
    localparam logic [2:0] ROW_BOTTOM = 3'd7;
    localparam logic [7:0] COL_START  = 8'b0001_0000;

    logic [2:0] row;
    logic [7:0] col;
    logic       valid;
    logic [7:0] moveCount;
    logic [7:0] dataReg;
    logic       goalReg;

    always_ff @(posedge SC_REGPOINT_MATRIX_CLOCK_50) begin
        if (SC_REGPOINT_MATRIX_RESET_InHigh) begin
            valid     <= 1'b0;
            row       <= ROW_BOTTOM;
            col       <= COL_START;
            moveCount <= 8'd0;
            dataReg   <= 8'h00;
            goalReg   <= 1'b0;
        end else begin
            goalReg <= 1'b0;

            // The scanner sees the position as it was before this edge.
            if (valid && (matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus == row))
                dataReg <= col;
            else
                dataReg <= 8'h00;

            if (!matrixBus.SC_REGPOINT_MATRIX_clear_InLow) begin
                valid     <= 1'b0;
                moveCount <= 8'd0;
            end else if (!matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow) begin
                valid     <= 1'b1;
                row       <= ROW_BOTTOM;
                col       <= COL_START;
                moveCount <= 8'd0;
            end else if (valid) begin
                if (!matrixBus.SC_REGPOINT_MATRIX_load0_InLow) begin
                    if (row != 3'd0) begin
                        row <= row - 3'd1;
                        if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
                        // The pulse rises together with the change to row 0.
                        // A frog that stays on row 0 cannot re-enter this branch.
                        if (row == 3'd1) goalReg <= 1'b1;
                    end
                end else if (!matrixBus.SC_REGPOINT_MATRIX_load1_InLow) begin
                    if (row != ROW_BOTTOM) begin
                        row <= row + 3'd1;
                        if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
                    end
                end else if (matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus == 2'b01) begin
                    if (!col[7]) begin
                        col <= {col[6:0], 1'b0};
                        if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
                    end
                end else if (matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus == 2'b10) begin
                    if (!col[0]) begin
                        col <= {1'b0, col[7:1]};
                        if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
                    end
                end
            end
        end
    end

    assign matrixBus.SC_REGPOINT_MATRIX_data_OutBus                 = dataReg;
    assign matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh                = goalReg;
    assign matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus            = moveCount;
    assign matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow = ~(valid && (row == ROW_BOTTOM));
    assign matrixBus.debugRow                                       = row;
    assign matrixBus.debugCol                                       = col;
    assign matrixBus.debugValid                                     = valid;
endmodule

// File: tb/tb_sc_regpoint_matrix.sv
// -----------------------------------------------------------------------------
// tb_sc_regpoint_matrix
// Directed test of sc_regpoint_matrix with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sc_regpoint_matrix;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sc_regpoint_matrix_if matrixBus ();

    sc_regpoint_matrix dut (
        .SC_REGPOINT_MATRIX_CLOCK_50     (clk),
        .SC_REGPOINT_MATRIX_RESET_InHigh (rst),
        .matrixBus                       (matrixBus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        matrixBus.SC_REGPOINT_MATRIX_clear_InLow          = 1'b1;
        matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow  = 1'b1;
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow          = 1'b1;
        matrixBus.SC_REGPOINT_MATRIX_load1_InLow          = 1'b1;
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b00;
    endtask

    task automatic default_screen();
        matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow = 1'b1;
    endtask

    initial begin
        idle();
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_data",   matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h00);
        check("rst_mc",     matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        check("rst_goal",   {7'd0, matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh}, 8'h00);
        check("rst_bottom", {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h01);
        check("rst_valid",  {7'd0, matrixBus.debugValid}, 8'h00);
        check("rst_row",    {5'd0, matrixBus.debugRow}, 8'h07);
        check("rst_col",    matrixBus.debugCol, 8'h10);
        rst = 1'b0;
        tick();
        check("post_rst_bottom", {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h01);

        // Default screen, then scan row 7
        default_screen();
        check("def_bottom", {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h00);
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd7;
        tick();
        check("def_data7", matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h10);
        check("def_mc",    matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd6;
        tick();
        check("def_data6", matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h00);

        // load1 at the bottom row is a no-op
        matrixBus.SC_REGPOINT_MATRIX_load1_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_load1_InLow = 1'b1;
        check("l1_row",    {5'd0, matrixBus.debugRow}, 8'h07);
        check("l1_mc",     matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        check("l1_bottom", {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h00);

        // Seven load0 pulses climb to row 0, goal pulses only after the 7th
        for (int i = 1; i <= 7; i++) begin
            matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b0;
            tick();
            matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b1;
            check("up_row",  {5'd0, matrixBus.debugRow}, 8'(7 - i));
            check("up_goal", {7'd0, matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh}, (i == 7) ? 8'h01 : 8'h00);
            tick();
            check("up_goal_gap", {7'd0, matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh}, 8'h00);
        end
        check("up_mc", matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'd7);
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd0;
        tick();
        check("up_data0", matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h10);
        // 8th pulse at row 0 is ignored
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b1;
        check("top_row",  {5'd0, matrixBus.debugRow}, 8'h00);
        check("top_mc",   matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'd7);
        check("top_goal", {7'd0, matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh}, 8'h00);

        // load1 moves down one row from the top
        matrixBus.SC_REGPOINT_MATRIX_load1_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_load1_InLow = 1'b1;
        check("down_row", {5'd0, matrixBus.debugRow}, 8'h01);
        check("down_mc",  matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'd8);

        // Shift left held 5 cycles: 20, 40, 80, then hold
        default_screen();
        check("sh_mc0", matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b01;
        tick(); check("shl_col1", matrixBus.debugCol, 8'h20);
        tick(); check("shl_col2", matrixBus.debugCol, 8'h40);
        tick(); check("shl_col3", matrixBus.debugCol, 8'h80);
        tick(); check("shl_col4", matrixBus.debugCol, 8'h80);
        tick(); check("shl_col5", matrixBus.debugCol, 8'h80);
        check("shl_mc", matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'd3);

        // Shift 11 holds
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b11;
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd7;
        tick();
        check("sh11_col", matrixBus.debugCol, 8'h80);
        tick();
        check("sh11_data", matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h80);

        // Shift right held 8 cycles: 40 .. 01, then hold at bit 0
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b10;
        for (int i = 0; i < 8; i++) tick();
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b00;
        check("shr_col", matrixBus.debugCol, 8'h01);
        check("shr_mc",  matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'd10);

        // Move counter saturates at 255
        default_screen();
        for (int i = 0; i < 260; i++) begin
            matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
        end
        matrixBus.SC_REGPOINT_MATRIX_shiftselection_InBus = 2'b00;
        check("sat_mc",  matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'hFF);
        check("sat_col", matrixBus.debugCol, 8'h10);

        // Clear wins over load0 in the same cycle
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b0;
        tick();
        check("pre_clr_row", {5'd0, matrixBus.debugRow}, 8'h06);
        matrixBus.SC_REGPOINT_MATRIX_clear_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_clear_InLow = 1'b1;
        check("clr_valid", {7'd0, matrixBus.debugValid}, 8'h00);
        check("clr_row",   {5'd0, matrixBus.debugRow}, 8'h06);
        check("clr_mc",    matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        // load0 still held while invalid: ignored
        for (int r = 0; r < 8; r++) begin
            matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'(r);
            tick();
            check("clr_data", matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h00);
        end
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b1;
        check("clr_row_held", {5'd0, matrixBus.debugRow}, 8'h06);
        check("clr_bottom",   {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h01);

        // Reset beats defaultscreen in the same cycle
        default_screen();
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b0;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_load0_InLow = 1'b1;
        matrixBus.SC_REGPOINT_MATRIX_rowselect_InBus = 3'd6;
        matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow = 1'b0;
        rst = 1'b1;
        tick();
        matrixBus.SC_REGPOINT_MATRIX_defaultscreen_InLow = 1'b1;
        check("rd_valid",  {7'd0, matrixBus.debugValid}, 8'h00);
        check("rd_row",    {5'd0, matrixBus.debugRow}, 8'h07);
        check("rd_col",    matrixBus.debugCol, 8'h10);
        check("rd_mc",     matrixBus.SC_REGPOINT_MATRIX_movecount_OutBus, 8'h00);
        check("rd_data",   matrixBus.SC_REGPOINT_MATRIX_data_OutBus, 8'h00);
        check("rd_goal",   {7'd0, matrixBus.SC_REGPOINT_MATRIX_goal_OutHigh}, 8'h00);
        check("rd_bottom", {7'd0, matrixBus.SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow}, 8'h01);
        rst = 1'b0;
        tick();
        check("rd_valid_after", {7'd0, matrixBus.debugValid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_regpoint_matrix.md
SC_REGPOINT_MATRIX -- requirements
Module: SC_REGPOINT_MATRIX

Interface
REQ-001 SHALL provide SC_REGPOINT_MATRIX_CLOCK_50  input  1  system clock; all state updates occur on its rising edge.
REQ-002 SHALL provide SC_REGPOINT_MATRIX_RESET_InHigh  input  1  reset, synchronous and active-high.
REQ-003 SHALL provide SC_REGPOINT_MATRIX_clear_InLow  input  1  blank the frog, active low.
REQ-004 SHALL provide SC_REGPOINT_MATRIX_defaultscreen_InLow  input  1  place the frog at its start position, active low.
REQ-005 SHALL provide SC_REGPOINT_MATRIX_load0_InLow  input  1  move up one row, active low.
REQ-006 SHALL provide SC_REGPOINT_MATRIX_load1_InLow  input  1  move down one row, active low.
REQ-007 SHALL provide SC_REGPOINT_MATRIX_shiftselection_InBus  input  2  column shift: 01 = left, 10 = right, 00/11 = hold.
REQ-008 SHALL provide SC_REGPOINT_MATRIX_rowselect_InBus  input  3  row index requested by the display scanner.
REQ-009 SHALL provide SC_REGPOINT_MATRIX_data_OutBus  output  8  registered column pattern of the selected row.
REQ-010 SHALL provide SC_REGPOINT_MATRIX_bottomsidecomparator_OutLow  output  1  low when the frog is visible in bottom row 7.
REQ-011 SHALL provide SC_REGPOINT_MATRIX_goal_OutHigh  output  1  one-cycle pulse when the frog reaches row 0.
REQ-012 SHALL provide SC_REGPOINT_MATRIX_movecount_OutBus  output  8  number of accepted moves.

Function
REQ-013 SHALL hold the following internal state:
  - row: 3 bits; 0 = top, 7 = bottom.
  - col: 8-bit one-hot; bit 7 = leftmost column.
  - valid: 1 bit.
REQ-014 SHALL accept at most one command per clock, with priority clear > defaultscreen > load0 > load1 > shift (01/10).
REQ-015 SHALL, on clear, set valid = 0, set movecount = 0 and leave row/col unchanged.
REQ-016 SHALL, on defaultscreen, set valid = 1, row = 7, col = 8'b00010000 and movecount = 0.
REQ-017 SHALL ignore load0, load1 and shift while valid = 0.
REQ-018 SHALL, on load0 with row > 0, decrement row; with row = 0 it SHALL hold (no wrap) and count no move.
REQ-019 SHALL, on load1 with row < 7, increment row; with row = 7 it SHALL hold and count no move.
REQ-020 SHALL, on shift 01, rotate col one bit toward bit 7 unless bit 7 is set; in that case hold and count no move.
REQ-021 SHALL, on shift 10, move col one bit toward bit 0 unless bit 0 is set; in that case hold and count no move.
REQ-022 SHALL increment movecount by 1 for each position change, saturating at 255.
REQ-023 SHALL pulse goal_OutHigh for exactly one cycle, the cycle after row changes from 1 to 0; it SHALL NOT pulse while row stays 0.
REQ-024 SHALL register data_OutBus one cycle after rowselect is sampled:
  - value = col when valid = 1 and rowselect = row;
  - value = 8'h00 otherwise.
REQ-025 SHALL drive bottomsidecomparator_OutLow combinationally: 0 when valid = 1 and row = 7, else 1.
REQ-026 SHALL treat commands as level-sensitive: a command held low for N cycles applies N times. Single-cycle pulsing is the upstream state machine's duty.

Reset
REQ-027 SHALL, while RESET_InHigh = 1 at a clock edge, load:
  - valid = 0, row = 7, col = 8'b00010000;
  - movecount = 0, data_OutBus = 8'h00, goal_OutHigh = 0.
REQ-028 SHALL give reset precedence over every command in the same cycle; reset mid-move discards that move.
REQ-029 SHALL drive bottomsidecomparator_OutLow = 1 during and after reset, until the next defaultscreen.

Verification
REQ-030 Reset, then defaultscreen for 1 cycle, then rowselect = 7 -> next cycle data_OutBus = 8'h10, bottomsidecomparator_OutLow = 0, movecount = 0.
REQ-031 After defaultscreen, 7 single-cycle load0 pulses, then 1 more -> goal_OutHigh pulses once, after the 7th pulse; row = 0; movecount = 7; the 8th pulse is ignored.
REQ-032 After defaultscreen, shift 01 held 5 cycles -> col = 8'h80 after 3 cycles, then holds; movecount = 3.
REQ-033 clear and load0 low in the same cycle -> valid = 0, row unchanged, data_OutBus = 8'h00 for every rowselect, load0 ignored.
REQ-034 load1 at row 7 -> row stays 7, movecount unchanged, bottomsidecomparator_OutLow stays 0.
REQ-035 RESET_InHigh asserted together with defaultscreen -> reset values per REQ-027, valid = 0.
